dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Sequences every data-memory access issued by the MEM stage of the RV32I pipeline. The block sits between the EX/MEM pipeline register and a handshaked data-memory port (req/gnt, rvalid). It does four things:
- builds word-aligned address, byte enables and lane-replicated store data from opcode/funct3;
- stalls the pipeline until the access completes;
- aligns and sign/zero-extends load data, presented as `DMEM_drdata_out` for capture by MEM/WB;
- flags misaligned or illegal accesses without touching memory.

## Interface
- No parameters; XLEN fixed at 32.
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `EM_op_out`  in  7  opcode in MEM stage; 7'b0000011 = load, 7'b0100011 = store, anything else = no access.
- `EM_funct3_out`  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores: 000/001/010 only).
- `EM_daddr_out`  in  32  byte address from ALU.
- `EM_storedata_out`  in  32  rs2 value for stores.
- `mem_req`  out  1  request valid; held until `mem_gnt`.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  {addr[31:2],2'b00}.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_gnt`  in  1  memory accepts request this cycle.
- `mem_rvalid`  in  1  read data valid; never in the same cycle as its `mem_gnt`.
- `mem_rdata`  in  32  raw read word.
- `DMEM_drdata_out`  out  32  aligned, extended load result (registered).
- `stall`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble into MEM/WB.
- `dmem_fault`  out  1  misaligned/illegal access pulse.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - Access present and legal: latch mem_addr/be/wdata/we and funct3/addr[1:0]; go to REQ.
  - Access present and illegal: `dmem_fault`=1 for that cycle, no request, stay IDLE.
- **REQ**
  - `mem_req`=1 and outputs stable until `mem_gnt`.
  - On gnt: store goes to DONE; load goes to WAIT.
- **WAIT**
  - On `mem_rvalid`: register extracted data into `DMEM_drdata_out`; go to DONE.
  - `mem_rvalid` in any other state is ignored.
- **DONE**
  - `stall`=0 so EX/MEM and MEM/WB advance at this edge; go to IDLE unconditionally.
  - This prevents re-issue of the same instruction.
- **Stall**
  - `stall` = (IDLE & legal access) | REQ | WAIT; combinational.
  - Illegal accesses do not stall.
- **Illegal access**
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠0.
  - Load funct3 ∈ {011,110,111}.
  - Store funct3 ∉ {000,001,010}.
- **Store lanes**
  - SB: wdata={4{sd[7:0]}}, be=4'b0001<<a.
  - SH: wdata={2{sd[15:0]}}, be=4'b0011<<a.
  - SW: wdata=sd, be=4'b1111.
  - Here a = addr[1:0].
- **Load extract**
  - Shift `mem_rdata` right by 8·a.
  - B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
  - Loads drive be=1111; the byte select comes from the latched a.
- `DMEM_drdata_out` holds its value until the next completed load; stores do not change it.

## Timing
- **Reset values:** state IDLE, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_be`=0, `mem_wdata`=0, `DMEM_drdata_out`=0. `stall` and `dmem_fault` follow from IDLE with the current inputs.
- **Zero-wait load:** IDLE → REQ (gnt) → WAIT (rvalid next cycle) → DONE. This is 3 stall cycles; the pipeline advances on the 4th edge.
- **Zero-wait store:** IDLE → REQ (gnt) → DONE. This is 2 stall cycles.
- Each cycle without gnt in REQ, or without rvalid in WAIT, adds exactly one stall cycle.
- **Reset mid-operation:** rst in REQ/WAIT/DONE returns to IDLE next edge and drops `mem_req`. A late `mem_rvalid` is then ignored in IDLE.
- Back-to-back accesses: the next instruction is sampled in IDLE the cycle after DONE.
- There are no idle bubbles beyond that one cycle.

## Test plan
- **Load word, zero wait:** LW addr 0x100, gnt in REQ, rdata 0xDEADBEEF next cycle.
  - Required: mem_addr 0x100, be 1111, stall high 3 cycles, DMEM_drdata_out 0xDEADBEEF in DONE.
- **LB vs LBU:** LB/LBU at 0x103, rdata 0x80123456.
  - Required: LB → 0xFFFFFF80; LBU → 0x00000080.
  - Repeat LH at 0x102, rdata 0x8001_0000 → 0xFFFF8001.
- **SB/SH lanes:** SB at 0x201 with sd 0x000000AB → be 0010, wdata 0xABABABAB. SH at 0x202 with sd 0x1234 → be 1100, wdata 0x12341234.
  - Required: store stall 2 cycles; DMEM_drdata_out unchanged.
- **Misaligned access:** LW at 0x102; SH at 0x301.
  - Required: dmem_fault=1 one cycle, mem_req never asserted, stall=0.
- **Wait states:** gnt delayed 3 cycles, rvalid delayed 2 cycles after gnt.
  - Required: mem_req/addr/be stable throughout REQ, stall high 7 cycles, correct data captured.
- **Reset mid-WAIT:** rst pulsed in WAIT, then rvalid arrives.
  - Required: next cycle state IDLE, mem_req 0, DMEM_drdata_out 0, late rvalid ignored.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// Handshaked data-memory port between dmem_ctrl (master) and memory (slave).
// req/gnt address phase, rvalid/rdata response phase; word address + byte enables.
interface dmem_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_be,
    output mem_wdata,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_be,
    input  mem_wdata,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory sequencer: lane/byte-enable build, stall, load align/extend.
// Ports: clk, rst, EM_* from EX/MEM, mem (master port), DMEM_drdata_out, stall, dmem_fault.
module dmem_ctrl (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         EM_op_out,
  input  logic [2:0]         EM_funct3_out,
  input  logic [31:0]        EM_daddr_out,
  input  logic [31:0]        EM_storedata_out,
  dmem_ctrl_if.master        mem,
  output logic [31:0]        DMEM_drdata_out,
  output logic               stall,
  output logic               dmem_fault
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_nxt;

  logic        is_load;
  logic        is_store;
  logic        access;
  logic        legal;
  logic [1:0]  a;
  logic [2:0]  f3;

  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;

  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic [1:0]  a_q;

  logic [31:0] shifted;
  logic [31:0] extracted;

  logic        start;

  assign is_load  = (EM_op_out == OP_LOAD);
  assign is_store = (EM_op_out == OP_STORE);
  assign access   = is_load | is_store;
  assign a        = EM_daddr_out[1:0];
  assign f3       = EM_funct3_out;

  // Legality: size/sign code must exist for the op,
  // and the address must be naturally aligned.
  always_comb begin
    legal = 1'b0;
    unique case (1'b1)
      is_load: begin
        unique case (f3)
          F3_B, F3_BU: legal = 1'b1;
          F3_H, F3_HU: legal = ~a[0];
          F3_W:        legal = (a == 2'b00);
          default:     legal = 1'b0;
        endcase
      end
      is_store: begin
        unique case (f3)
          F3_B:    legal = 1'b1;
          F3_H:    legal = ~a[0];
          F3_W:    legal = (a == 2'b00);
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  // Store lanes are replicated so the byte enables alone
  // pick the target byte/half within the word.
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = 32'h0;
    if (is_store) begin
      unique case (f3)
        F3_B: begin
          be_nxt    = 4'b0001 << a;
          wdata_nxt = {4{EM_storedata_out[7:0]}};
        end
        F3_H: begin
          be_nxt    = 4'b0011 << a;
          wdata_nxt = {2{EM_storedata_out[15:0]}};
        end
        default: begin
          be_nxt    = 4'b1111;
          wdata_nxt = EM_storedata_out;
        end
      endcase
    end
  end

  assign start = (state == S_IDLE) & access & legal;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (mem.mem_gnt) begin
          state_nxt = we_q ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem.mem_rvalid) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Load extract uses the byte offset captured with the request,
  // since the EX/MEM inputs are only guaranteed stable while stalled.
  assign shifted = mem.mem_rdata >> {a_q, 3'b000};

  always_comb begin
    unique case (f3_q)
      F3_B:    extracted = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   extracted = {24'h0, shifted[7:0]};
      F3_H:    extracted = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   extracted = {16'h0, shifted[15:0]};
      default: extracted = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      we_q            <= 1'b0;
      addr_q          <= 32'h0;
      be_q            <= 4'h0;
      wdata_q         <= 32'h0;
      f3_q            <= 3'b000;
      a_q             <= 2'b00;
      DMEM_drdata_out <= 32'h0;
    end else begin
      state <= state_nxt;
      if (start) begin
        we_q    <= is_store;
        addr_q  <= {EM_daddr_out[31:2], 2'b00};
        be_q    <= be_nxt;
        wdata_q <= wdata_nxt;
        f3_q    <= f3;
        a_q     <= a;
      end
      if ((state == S_WAIT) && mem.mem_rvalid) begin
        DMEM_drdata_out <= extracted;
      end
    end
  end

  assign mem.mem_req   = (state == S_REQ);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

  // DONE releases the pipeline so the instruction is not re-issued.
  assign stall = start
               | (state == S_REQ)
               | (state == S_WAIT);

  assign dmem_fault = (state == S_IDLE) & access & ~legal;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized self-checking bench for dmem_ctrl with a behavioural memory model.
// Directed spec scenarios first, then random loads/stores/no-ops with random latency.
module tb_dmem_ctrl;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] NOP = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [31:0] daddr;
  logic [31:0] sdata;
  logic [31:0] drdata;
  logic        stall;
  logic        fault;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] exp_rd = 32'h0;

  always #5 clk = ~clk;

  dmem_ctrl_if mif ();

  dmem_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .EM_op_out        (op),
    .EM_funct3_out    (f3),
    .EM_daddr_out     (daddr),
    .EM_storedata_out (sdata),
    .mem              (mif),
    .DMEM_drdata_out  (drdata),
    .stall            (stall),
    .dmem_fault       (fault)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic bit illegal(input logic [6:0] o,
                                 input logic [2:0] f,
                                 input logic [31:0] ad);
    int off;
    off = int'(ad % 4);
    if (o == LD) begin
      if (!(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
      if ((f == 3'd1 || f == 3'd5) && (off % 2) != 0) return 1'b1;
      if (f == 3'd2 && off != 0) return 1'b1;
      return 1'b0;
    end
    if (o == ST) begin
      if (!(f inside {3'd0, 3'd1, 3'd2})) return 1'b1;
      if (f == 3'd1 && (off % 2) != 0) return 1'b1;
      if (f == 3'd2 && off != 0) return 1'b1;
      return 1'b0;
    end
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [6:0] o,
                                        input logic [2:0] f,
                                        input logic [31:0] ad);
    int off;
    off = int'(ad % 4);
    if (o == ST && f == 3'd0) return 4'(1 << off);
    if (o == ST && f == 3'd1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] f,
                                         input logic [31:0] sd);
    if (f == 3'd0) return (sd % 256) * 32'h01010101;
    if (f == 3'd1) return (sd % 65536) * 32'h00010001;
    return sd;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f,
                                           input logic [31:0] ad,
                                           input logic [31:0] w);
    logic [31:0] v;
    logic [31:0] b;
    logic [31:0] h;
    v = w / (32'd1 << (8 * (ad % 4)));
    b = v % 256;
    h = v % 65536;
    case (f)
      3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd5:    return h;
      default: return v;
    endcase
  endfunction

  // One MEM-stage instruction; called just after a falling edge.
  task automatic access(input string tag,
                        input logic [6:0] o,
                        input logic [2:0] f,
                        input logic [31:0] ad,
                        input logic [31:0] sd,
                        input logic [31:0] rd,
                        input int gd,
                        input int rvd);
    int  cyc, nstall, nreq, nfault, since, bad;
    bit  gseen, done, acc, ill, gnt, rv;
    logic fault0;
    int  exp_st;
    acc = (o == LD) || (o == ST);
    ill = illegal(o, f, ad);
    op = o; f3 = f; daddr = ad; sdata = sd;
    cyc = 0; nstall = 0; nreq = 0; nfault = 0;
    since = 0; bad = 0; gseen = 0; done = 0;
    fault0 = 1'b0;
    while (!done && cyc < 64) begin
      #1;
      if (cyc == 0) fault0 = fault;
      if (stall) nstall++;
      if (fault) nfault++;
      if (gseen) since++;
      gnt = 1'b0;
      if (mif.mem_req === 1'b1) begin
        nreq++;
        if (mif.mem_addr !== {ad[31:2], 2'b00}) bad++;
        if (mif.mem_be !== exp_be(o, f, ad)) bad++;
        if (mif.mem_we !== (o == ST)) bad++;
        if (o == ST && mif.mem_wdata !== exp_wd(f, sd)) bad++;
        gnt = (nreq - 1 == gd);
      end
      rv = gseen && (o == LD) && (since == rvd);
      mif.mem_gnt    = gnt;
      mif.mem_rvalid = rv;
      mif.mem_rdata  = rv ? rd : $urandom;
      if (!rv && !gnt && mif.mem_req === 1'b1
          && $urandom_range(0, 3) == 0)
        mif.mem_rvalid = 1'b1;
      if (gnt) begin
        gseen = 1'b1;
        since = 0;
      end
      if (stall === 1'b0) done = 1'b1;
      @(negedge clk);
      cyc++;
    end
    mif.mem_gnt    = 1'b0;
    mif.mem_rvalid = 1'b0;
    if (!acc || ill) exp_st = 0;
    else if (o == LD) exp_st = 2 + gd + rvd;
    else exp_st = 2 + gd;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_stall"}, nstall, exp_st);
    chk({tag, "_nreq"}, nreq, (acc && !ill) ? gd + 1 : 0);
    chk({tag, "_fault"}, {nfault[30:0], fault0}, {31'(ill), ill});
    if (acc && !ill) chk({tag, "_bus"}, bad, 0);
    if (o == LD && !ill) exp_rd = load_val(f, ad, rd);
    chk({tag, "_rdata"}, drdata, exp_rd);
  endtask

  initial begin
    logic [6:0]  o;
    logic [2:0]  f;
    logic [31:0] ad;
    int          k;
    rst = 1'b1;
    op = NOP; f3 = 3'd0; daddr = 32'h0; sdata = 32'h0;
    mif.mem_gnt = 1'b0;
    mif.mem_rvalid = 1'b0;
    mif.mem_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", 32'(mif.mem_req), 32'd0);
    chk("rst_we", 32'(mif.mem_we), 32'd0);
    chk("rst_addr", mif.mem_addr, 32'h0);
    chk("rst_be", 32'(mif.mem_be), 32'h0);
    chk("rst_wdata", mif.mem_wdata, 32'h0);
    chk("rst_rdata", drdata, 32'h0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    access("lw", LD, 3'd2, 32'h100, 0, 32'hDEADBEEF, 0, 1);
    chk("lw_const", drdata, 32'hDEADBEEF);
    access("lb", LD, 3'd0, 32'h103, 0, 32'h80123456, 0, 1);
    chk("lb_const", drdata, 32'hFFFFFF80);
    access("lbu", LD, 3'd4, 32'h103, 0, 32'h80123456, 0, 1);
    chk("lbu_const", drdata, 32'h00000080);
    access("lh", LD, 3'd1, 32'h102, 0, 32'h80010000, 0, 1);
    chk("lh_const", drdata, 32'hFFFF8001);
    access("sb", ST, 3'd0, 32'h201, 32'h000000AB, 0, 0, 1);
    access("sh", ST, 3'd1, 32'h202, 32'h00001234, 0, 0, 1);
    chk("st_keep", drdata, 32'hFFFF8001);
    access("mis_lw", LD, 3'd2, 32'h102, 0, 0, 0, 1);
    access("mis_sh", ST, 3'd1, 32'h301, 32'h55, 0, 0, 1);
    access("wait", LD, 3'd2, 32'h180, 0, 32'hCAFEF00D, 3, 2);
    chk("wait_const", drdata, 32'hCAFEF00D);

    // reset while waiting for read data
    op = LD; f3 = 3'd2; daddr = 32'h40;
    @(negedge clk);
    chk("rw_req", 32'(mif.mem_req), 32'd1);
    mif.mem_gnt = 1'b1;
    @(negedge clk);
    mif.mem_gnt = 1'b0;
    rst = 1'b1;
    op = NOP;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rw_req0", 32'(mif.mem_req), 32'd0);
    chk("rw_stall", 32'(stall), 32'd0);
    chk("rw_rdata", drdata, 32'h0);
    exp_rd = 32'h0;
    mif.mem_rvalid = 1'b1;
    mif.mem_rdata = 32'h12345678;
    @(negedge clk);
    mif.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("rw_late", drdata, 32'h0);
    chk("rw_idle", 32'(stall | mif.mem_req), 32'd0);

    for (int i = 0; i < 200; i++) begin
      k = int'($urandom_range(0, 9));
      o = (k < 4) ? LD : (k < 8) ? ST : NOP;
      f = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f = (o == ST) ? 3'($urandom_range(0, 2))
                                                   : f;
      ad = $urandom;
      if ($urandom_range(0, 1) == 1) ad = {ad[31:2], 2'b00};
      access("rnd", o, f, ad, $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
